vend_ctrl_param: RTL and testbench
==================================

Name: vend_ctrl_param

Overview:
- Parametrised successor to the single-product coin accumulator: a multi-product soda vending FSM.
- Accepts coins (5/10/25/100c), waits for a product selection once credit reaches PRICE, then asserts one vend line for a timed interval.
- Keeps a running total since the last clear, and presents that total on a display register when the clear button is pressed and released.
- Sits between the coin/button front-end (already debounced, one-cycle pulses) and the vend actuators and display.

Parameters:
- CLK_HZ, 100, clock frequency in Hz.
- VEND_CYCLES, CLK_HZ, number of cycles the vend line stays high (1 s).
- PRICE, 70, item cost in cents; all products cost the same.
- NUM_PROD, 3, number of products (one vend line each); must be >= 1.
- SEL_W, 2, width of sel_id; must satisfy 2^SEL_W >= NUM_PROD.
- AMT_W, 8, credit width; must hold PRICE-5+100.
- TOT_W, 16, accumulated-total width; wraps modulo 2^TOT_W.
- CHANGE_EN, 0, 1 = report change owed at vend start; 0 = keep excess, no change.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high; clock clk.
- coin_valid, in, 1, one-cycle pulse: coin inserted.
- coin_type, in, 2, coin code: 00=5c, 01=10c, 10=25c, 11=100c.
- coin_ready, out, 1, high when coins are accepted (COLLECT state).
- sel_valid, in, 1, one-cycle pulse: product button pressed.
- sel_id, in, SEL_W, product index, 0..NUM_PROD-1.
- clr_req, in, 1, one-cycle pulse on release of button R.
- vend, out, NUM_PROD, one-hot vend lines.
- credit, out, AMT_W, credit inserted for the current purchase.
- total_disp, out, TOT_W, total accumulated between the last two clears.
- change_valid, out, 1, one-cycle pulse when change is owed (CHANGE_EN=1 only).
- change_amt, out, AMT_W, credit-PRICE; valid with change_valid.
- sel_err, out, 1, one-cycle pulse when sel_id >= NUM_PROD.

Behaviour:
- Reset (async): state=COLLECT; credit, internal total_acc, total_disp, vend, change_*, sel_err, vend timer all 0.
  - coin_ready=1 from the first clock edge after reset deasserts.
- COLLECT: coin_ready=1.
  - A coin_valid in cycle N adds the coin value to credit and to total_acc; the new value is visible at N+1.
  - If the new credit >= PRICE, next state is WAIT_SEL.
  - sel_valid in COLLECT is ignored (no sel_err).
- WAIT_SEL: coin_ready=0; coin_valid is ignored and not counted.
  - sel_valid with sel_id < NUM_PROD in cycle N: vend[sel_id]=1 during cycles N+1..N+VEND_CYCLES.
  - If CHANGE_EN=1 and credit>PRICE, change_valid pulses at N+1 with change_amt=credit-PRICE.
  - credit clears to 0 at N+1. State becomes VEND.
  - sel_id >= NUM_PROD: sel_err pulses at N+1; stay in WAIT_SEL with credit unchanged.
- VEND: coin_ready=0; coins and selections are ignored.
  - The timer counts VEND_CYCLES; on the last vend cycle the next state is COLLECT.
  - vend falls and coin_ready rises at N+VEND_CYCLES+1.
- Clear (clr_req) has priority over every event in every state, including mid-vend.
  - Next cycle: total_disp <= total_acc; total_acc <= 0; credit <= 0; vend <= 0; timer <= 0; state <= COLLECT.
  - A coin arriving in the same cycle as clr_req is dropped and counted nowhere.
- Arithmetic:
  - credit never exceeds PRICE+95, so it cannot overflow given the AMT_W rule.
  - total_acc wraps modulo 2^TOT_W with no saturation.
- vend is always one-hot or zero; at most one vend line is ever high.
- Only the three states above exist. Illegal state encodings recover to COLLECT.

Decomposition:
- Package vend_pkg holds:
  - the coin_type encodings and the coin-value constants (5/10/25/100);
  - the state enum (COLLECT, WAIT_SEL, VEND);
  - a coin_value function mapping coin_type to cents.
- One natural sub-module: vend_timer, a loadable down-counter of width $clog2(VEND_CYCLES+1) with start/done signals, reused for any future timed outputs.

Test Plan:
- Reset, then dime x7 (70c) -> credit steps 10..70; WAIT_SEL entered; coin_ready=0; a further quarter is ignored (credit stays 70, total 70).
- Credit 70, sel_id=1 at cycle N -> vend=3'b010 for exactly 100 cycles; credit=0 at N+1; coin_ready=1 at N+101.
- CHANGE_EN=1: quarter, quarter, dollar (150c), sel_id=2 -> change_valid pulse at N+1 with change_amt=80; vend=3'b100.
- Two purchases at 70c and 150c, then clr_req -> total_disp=220; credit=0; a subsequent clr_req with no coins gives total_disp=0.
- clr_req 40 cycles into vend -> vend=0 and state COLLECT next cycle; a coin_valid in the same cycle as clr_req is not counted.
- sel_id=3 with NUM_PROD=3 in WAIT_SEL -> sel_err one-cycle pulse, no vend, credit unchanged; a following sel_id=0 vends normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller:
// coin encodings, coin values and the controller state set.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    localparam int unsigned VAL_5   = 5;
    localparam int unsigned VAL_10  = 10;
    localparam int unsigned VAL_25  = 25;
    localparam int unsigned VAL_100 = 100;

    typedef enum logic [1:0] {
        COLLECT  = 2'b00,
        WAIT_SEL = 2'b01,
        VEND     = 2'b10
    } state_e;

    // Cents for a coin code; 7 bits is enough for the largest coin.
    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:   coin_value = 7'(VAL_5);
            COIN_10:  coin_value = 7'(VAL_10);
            COIN_25:  coin_value = 7'(VAL_25);
            default:  coin_value = 7'(VAL_100);
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter: start loads CYCLES, done is high on the last
// counted cycle, clear aborts the count.
module vend_timer #(
    parameter  int CYCLES = 100,
    localparam int W      = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic done
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (start)
            count <= W'(CYCLES);
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/vend_ctrl_param.sv
// Multi-product vending FSM: collects coins up to PRICE, vends the selected
// product for VEND_CYCLES, and latches the running total on clear.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int CLK_HZ      = 100,
    parameter int VEND_CYCLES = CLK_HZ,
    parameter int PRICE       = 70,
    parameter int NUM_PROD    = 3,
    parameter int SEL_W       = 2,
    parameter int AMT_W       = 8,
    parameter int TOT_W       = 16,
    parameter int CHANGE_EN   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_ready,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                clr_req,
    output logic [NUM_PROD-1:0] vend,
    output logic [AMT_W-1:0]    credit,
    output logic [TOT_W-1:0]    total_disp,
    output logic                change_valid,
    output logic [AMT_W-1:0]    change_amt,
    output logic                sel_err
);

    state_e              state, state_next;
    logic [AMT_W-1:0]    credit_next;
    logic [TOT_W-1:0]    total_acc, total_next, disp_next;
    logic [NUM_PROD-1:0] vend_next;
    logic                change_valid_next, sel_err_next;
    logic [AMT_W-1:0]    change_amt_next;
    logic                timer_start, timer_clear, timer_done;

    vend_timer #(.CYCLES(VEND_CYCLES)) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .clear (timer_clear),
        .done  (timer_done)
    );

    assign coin_ready = (state == COLLECT);

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next        = state;
        credit_next       = credit;
        total_next        = total_acc;
        disp_next         = total_disp;
        vend_next         = vend;
        change_valid_next = 1'b0;
        change_amt_next   = '0;
        sel_err_next      = 1'b0;
        timer_start       = 1'b0;
        timer_clear       = 1'b0;

        // Clear wins over every other event, including a coin in the same cycle.
        if (clr_req) begin
            disp_next   = total_acc;
            total_next  = '0;
            credit_next = '0;
            vend_next   = '0;
            timer_clear = 1'b1;
            state_next  = COLLECT;
        end else begin
            case (state)
                COLLECT: begin
                    if (coin_valid) begin
                        credit_next = credit + AMT_W'(coin_value(coin_type));
                        total_next  = total_acc + TOT_W'(coin_value(coin_type));
                        if (credit_next >= AMT_W'(PRICE))
                            state_next = WAIT_SEL;
                    end
                end
                WAIT_SEL: begin
                    if (sel_valid) begin
                        if (int'(sel_id) < NUM_PROD) begin
                            vend_next   = NUM_PROD'(1) << sel_id;
                            credit_next = '0;
                            timer_start = 1'b1;
                            state_next  = VEND;
                            if (CHANGE_EN != 0 && credit > AMT_W'(PRICE)) begin
                                change_valid_next = 1'b1;
                                change_amt_next   = credit - AMT_W'(PRICE);
                            end
                        end else begin
                            sel_err_next = 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (timer_done) begin
                        vend_next  = '0;
                        state_next = COLLECT;
                    end
                end
                default: begin
                    state_next  = COLLECT;
                    credit_next = '0;
                    vend_next   = '0;
                    timer_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= COLLECT;
            credit       <= '0;
            total_acc    <= '0;
            total_disp   <= '0;
            vend         <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            sel_err      <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            total_acc    <= total_next;
            total_disp   <= disp_next;
            vend         <= vend_next;
            change_valid <= change_valid_next;
            change_amt   <= change_amt_next;
            sel_err      <= sel_err_next;
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: a purchase-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vend_ctrl_param;

    localparam int VEND_CYCLES = 100;
    localparam int PRICE       = 70;
    localparam int NUM_PROD    = 3;
    localparam int SEL_W       = 2;
    localparam int AMT_W       = 8;
    localparam int TOT_W       = 16;
    localparam int CHANGE_EN   = 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin_type = 2'b00;
    logic                sel_valid = 1'b0;
    logic [SEL_W-1:0]    sel_id = '0;
    logic                clr_req = 1'b0;
    logic                coin_ready;
    logic [NUM_PROD-1:0] vend;
    logic [AMT_W-1:0]    credit;
    logic [TOT_W-1:0]    total_disp;
    logic                change_valid;
    logic [AMT_W-1:0]    change_amt;
    logic                sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_ctrl_param #(
        .CLK_HZ      (100),
        .VEND_CYCLES (VEND_CYCLES),
        .PRICE       (PRICE),
        .NUM_PROD    (NUM_PROD),
        .SEL_W       (SEL_W),
        .AMT_W       (AMT_W),
        .TOT_W       (TOT_W),
        .CHANGE_EN   (CHANGE_EN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .coin_ready   (coin_ready),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .clr_req      (clr_req),
        .vend         (vend),
        .credit       (credit),
        .total_disp   (total_disp),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .sel_err      (sel_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Purchase-level model: waiting for a selection means credit >= PRICE,
    // vending means cycles remain on the vend interval.
    typedef struct packed {
        int credit;
        int total;
        int disp;
        int left;
        int prod;
        bit cv;
        int amt;
        bit err;
    } model_t;

    model_t m = '0;

    function automatic int cents(input logic [1:0] t);
        case (t)
            2'd0:    return 5;
            2'd1:    return 10;
            2'd2:    return 25;
            default: return 100;
        endcase
    endfunction

    function automatic model_t model_next(input model_t cur);
        model_t n;
        n     = cur;
        n.cv  = 1'b0;
        n.amt = 0;
        n.err = 1'b0;
        if (reset) begin
            n = '0;
        end else if (clr_req) begin
            n.disp   = cur.total;
            n.total  = 0;
            n.credit = 0;
            n.left   = 0;
        end else if (cur.left > 0) begin
            n.left = cur.left - 1;
        end else if (cur.credit >= PRICE) begin
            if (sel_valid) begin
                if (int'(sel_id) < NUM_PROD) begin
                    if (CHANGE_EN != 0 && cur.credit > PRICE) begin
                        n.cv  = 1'b1;
                        n.amt = cur.credit - PRICE;
                    end
                    n.credit = 0;
                    n.left   = VEND_CYCLES;
                    n.prod   = int'(sel_id);
                end else begin
                    n.err = 1'b1;
                end
            end
        end else if (coin_valid) begin
            n.credit = cur.credit + cents(coin_type);
            n.total  = (cur.total + cents(coin_type)) % (1 << TOT_W);
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    always @(negedge clk) begin
        if (!reset) begin
            check("coin_ready", coin_ready, (m.left == 0 && m.credit < PRICE));
            check("vend", vend, (m.left > 0) ? (1 << m.prod) : 0);
            check("credit", credit, m.credit);
            check("total_disp", total_disp, m.disp);
            check("change_valid", change_valid, m.cv);
            if (m.cv) check("change_amt", change_amt, m.amt);
            check("sel_err", sel_err, m.err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick(1);
        coin_valid = 1'b0;
    endtask

    task automatic press(input logic [SEL_W-1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick(1);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset coin_ready", coin_ready, 1);
        check("reset credit", credit, 0);
        check("reset vend", vend, 0);
        check("reset total_disp", total_disp, 0);

        // Selection while collecting is ignored.
        press(2'd0);
        check("collect sel_err", sel_err, 0);
        check("collect vend", vend, 0);

        // Seven dimes reach the price exactly.
        for (int i = 0; i < 7; i++) begin
            put_coin(2'b01);
            check("dime credit", credit, 10 * (i + 1));
        end
        check("wait_sel coin_ready", coin_ready, 0);
        put_coin(2'b10);
        check("ignored quarter credit", credit, 70);

        // Vend product 1 for exactly VEND_CYCLES; a mid-vend coin is ignored.
        press(2'd1);
        check("vend1 line", vend, 3'b010);
        check("vend1 credit", credit, 0);
        check("vend1 no change", change_valid, 0);
        coin_valid = 1'b1;
        coin_type  = 2'b00;
        tick(1);
        coin_valid = 1'b0;
        tick(98);
        check("vend1 last cycle", vend, 3'b010);
        check("vend1 last coin_ready", coin_ready, 0);
        tick(1);
        check("vend1 end vend", vend, 0);
        check("vend1 end coin_ready", coin_ready, 1);

        // 150c purchase with change.
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b11);
        check("150 credit", credit, 150);
        press(2'd2);
        check("change_valid", change_valid, 1);
        check("change_amt", change_amt, 80);
        check("vend2 line", vend, 3'b100);
        tick(1);
        check("change pulse width", change_valid, 0);
        tick(99);
        check("vend2 end", vend, 0);

        // Clear shows 70 + 150, then a second clear shows nothing.
        pulse_clear();
        check("clear total_disp", total_disp, 220);
        check("clear credit", credit, 0);
        pulse_clear();
        check("second clear total_disp", total_disp, 0);

        // Clear 40 cycles into a vend, with a coin in the same cycle.
        put_coin(2'b11);
        press(2'd0);
        check("vend0 line", vend, 3'b001);
        check("vend0 change_amt", change_amt, 30);
        tick(39);
        check("vend0 cycle 40", vend, 3'b001);
        clr_req    = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'b01;
        tick(1);
        clr_req    = 1'b0;
        coin_valid = 1'b0;
        check("midvend clear vend", vend, 0);
        check("midvend clear coin_ready", coin_ready, 1);
        check("midvend clear credit", credit, 0);
        check("midvend clear total_disp", total_disp, 100);
        pulse_clear();
        check("dropped coin total_disp", total_disp, 0);

        // Out-of-range selection, then a valid one.
        for (int i = 0; i < 7; i++) put_coin(2'b01);
        press(2'd3);
        check("sel_err pulse", sel_err, 1);
        check("sel_err vend", vend, 0);
        check("sel_err credit", credit, 70);
        tick(1);
        check("sel_err width", sel_err, 0);
        press(2'd0);
        check("after err vend", vend, 3'b001);
        check("after err credit", credit, 0);
        tick(100);
        check("after err end vend", vend, 0);
        check("after err coin_ready", coin_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
